// File: rtl/param_data_memory_if.sv
// Request/response bus for param_data_memory.
// The master issues requests; the slave (memory) answers reads.
interface param_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata,
    input  busy
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata,
    output busy
  );
endinterface

// File: rtl/param_data_memory.sv
// Byte-enabled single-port data RAM with pipelined reads (RD_LAT 1 or 2).
// Optional zero sweep after reset is built when DMEM_CLEAR_EN is defined.
module param_data_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  param_data_memory_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W =
    (ADDR_W+1)'(DEPTH);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {
    RST, CLEAR, IDLE
  } state_t;
`else
  typedef enum logic [1:0] {
    RST, IDLE
  } state_t;
`endif

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic hit;
  logic acc;
  logic wr_acc;
  logic rd_acc;

  assign bus.req_ready = (state == IDLE);
  assign acc    = bus.req_valid & bus.req_ready;
  assign wr_acc = acc & bus.req_wen;
  assign rd_acc = acc & ~bus.req_wen;
  assign hit    = {1'b0, bus.req_addr} < DEPTH_W;

`ifdef DMEM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] cnt;
  logic clr;

  assign clr      = (state == CLEAR);
  assign bus.busy = clr;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= cnt + 1'b1;
  end
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= RST;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
`ifdef DMEM_CLEAR_EN
      RST:   state_nxt = CLEAR;
      CLEAR: if (cnt == LAST) state_nxt = IDLE;
`else
      RST:   state_nxt = IDLE;
`endif
      IDLE:  state_nxt = IDLE;
      default: state_nxt = RST;
    endcase
  end

  // Sweep and requests never overlap: ready is low while clearing.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (clr)
      mem[cnt] <= '0;
    else
`endif
    if (wr_acc && hit) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i])
          mem[bus.req_addr][i*8 +: 8] <=
            bus.req_wdata[i*8 +: 8];
      end
    end
  end

  logic              v1;
  logic [DATA_W-1:0] d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc)
        d1 <= hit ? mem[bus.req_addr] : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1)
            d2 <= d1;
        end
      end

      assign bus.rsp_valid = v2;
      assign bus.rsp_rdata = d2;
    end else begin : g_lat1
      assign bus.rsp_valid = v1;
      assign bus.rsp_rdata = d1;
    end
  endgenerate
endmodule
